// File: rtl/hazard_unit_v2.sv
// Hazard unit for the 5-stage MIPS pipeline. It decides D-stage stalls and E-stage flushes, selects forwarding
// sources, and tracks the mult/div busy window. Each E/M/W record holds {wreg,tnew}, and tnew counts down locally.
module hazard_unit_v2 #(
  parameter int REG_W       = 5,
  parameter int TW          = 3,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic [TW-1:0]    d_tuse_rs,
  input  logic [TW-1:0]    d_tuse_rt,
  input  logic [REG_W-1:0] d_wreg,
  input  logic [TW-1:0]    d_tnew,
  input  logic             d_md_start,
  input  logic             d_md_is_div,
  input  logic             d_md_use,
  output logic             stall,
  output logic             flush_e,
  output logic [1:0]       fwd_rs_d,
  output logic [1:0]       fwd_rt_d,
  output logic [1:0]       fwd_rs_e,
  output logic [1:0]       fwd_rt_e,
  output logic             md_busy
);

  localparam int MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int MD_W   = $clog2(MD_MAX + 1);

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_E    = 2'd1;
  localparam logic [1:0] SRC_M    = 2'd2;
  localparam logic [1:0] SRC_W    = 2'd3;

  typedef struct packed {
    logic [REG_W-1:0] wreg;
    logic [TW-1:0]    tnew;
  } dst_t;

  dst_t             r_e, r_m, r_w;
  logic [REG_W-1:0] r_e_rs, r_e_rt;
  logic [MD_W-1:0]  r_md_cnt;

  logic [2:0] w_rs_chk, w_rt_chk;
  logic [1:0] w_rs_fwd_e, w_rt_fwd_e;
  logic       w_md_busy, w_md_stall, w_stall;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // Returns {stall, fwd_code}. The search visits E, then M, then W, so the youngest writer hides the older ones.
  function automatic logic [2:0] src_check(input logic [REG_W-1:0] r, input logic [TW-1:0] tuse,
                                           input dst_t e, input dst_t m, input dst_t w);
    logic [1:0]    code;
    logic [TW-1:0] tn;
    // NOTE: every local gets a default before the branches. No path can leave it unassigned, so no latch is inferred.
    code = SRC_NONE;
    tn   = '0;
    if (r != '0 && tuse != '1) begin
      if (e.wreg == r) begin
        code = SRC_E;
        tn   = e.tnew;
      end else if (m.wreg == r) begin
        code = SRC_M;
        tn   = m.tnew;
      end else if (w.wreg == r) begin
        code = SRC_W;
        tn   = w.tnew;
      end
    end
    return {(tn > tuse), (tn == '0) ? code : SRC_NONE};
  endfunction

  function automatic logic [1:0] e_fwd(input logic [REG_W-1:0] r, input dst_t m, input dst_t w);
    logic [1:0] code;
    code = 2'd0;
    if (r != '0) begin
      if (m.wreg == r && m.tnew == '0)      code = 2'd1;
      else if (w.wreg == r && w.tnew == '0) code = 2'd2;
    end
    return code;
  endfunction

  assign w_rs_chk   = src_check(d_rs, d_tuse_rs, r_e, r_m, r_w);
  assign w_rt_chk   = src_check(d_rt, d_tuse_rt, r_e, r_m, r_w);
  assign w_rs_fwd_e = e_fwd(r_e_rs, r_m, r_w);
  assign w_rt_fwd_e = e_fwd(r_e_rt, r_m, r_w);

  assign w_md_busy  = (r_md_cnt != '0);
  assign w_md_stall = d_valid & (d_md_start | d_md_use) & w_md_busy;
  assign w_stall    = (d_valid & (w_rs_chk[2] | w_rt_chk[2])) | w_md_stall;

  // Every output is held at zero while reset is asserted.
  assign stall    = reset & w_stall;
  assign flush_e  = reset & w_stall;
  assign md_busy  = reset & w_md_busy;
  assign fwd_rs_d = reset ? w_rs_chk[1:0] : 2'd0;
  assign fwd_rt_d = reset ? w_rt_chk[1:0] : 2'd0;
  assign fwd_rs_e = reset ? w_rs_fwd_e : 2'd0;
  assign fwd_rt_e = reset ? w_rt_fwd_e : 2'd0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: use non-blocking assignments here. Every stage then shifts from the values it held before the clock edge.
      r_e      <= '0;
      r_e_rs   <= '0;
      r_e_rt   <= '0;
      r_m      <= '0;
      r_w      <= '0;
      r_md_cnt <= '0;
    end else begin
      if (d_valid && !w_stall) begin
        r_e    <= '{wreg: d_wreg, tnew: d_tnew};
        r_e_rs <= d_rs;
        r_e_rt <= d_rt;
      end else begin
        r_e    <= '0;
        r_e_rs <= '0;
        r_e_rt <= '0;
      end
      r_m <= '{wreg: r_e.wreg, tnew: sat_dec(r_e.tnew)};
      r_w <= '{wreg: r_m.wreg, tnew: sat_dec(r_m.tnew)};

      // A new mult/div load takes priority over the countdown.
      if (d_valid && d_md_start && !w_stall)
        r_md_cnt <= d_md_is_div ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
      else if (w_md_busy)
        r_md_cnt <= r_md_cnt - MD_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit_v2.sv
// Directed bench for hazard_unit_v2. A model tracks in-flight instructions by issue cycle and is compared
// against the unit every cycle, with literal expectations at the key points of each scenario.
module tb_hazard_unit_v2;

  localparam int REG_W = 5;
  localparam int TW    = 3;
  localparam int NOUSE = 7;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             d_valid = 1'b0;
  logic [REG_W-1:0] d_rs = '0, d_rt = '0, d_wreg = '0;
  logic [TW-1:0]    d_tuse_rs = '1, d_tuse_rt = '1, d_tnew = '0;
  logic             d_md_start = 1'b0, d_md_is_div = 1'b0, d_md_use = 1'b0;
  logic             stall, flush_e, md_busy;
  logic [1:0]       fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  always #5 clk = ~clk;

  hazard_unit_v2 dut (
    .clk(clk), .reset(reset), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wreg(d_wreg), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_is_div(d_md_is_div), .d_md_use(d_md_use),
    .stall(stall), .flush_e(flush_e),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
    .md_busy(md_busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each instruction issued into E is remembered together with its issue cycle. Its age then gives its stage
  // (0=E, 1=M, 2=W), and tnew0-age gives its remaining latency.
  typedef struct {
    logic [REG_W-1:0] wreg;
    int               tnew0;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    int               issue;
  } inflight_t;

  inflight_t q[$];
  int        cyc = 0;
  int        md_end = -1;
  bit        exp_stall_q = 0;

  function automatic int age_of(inflight_t e);
    return cyc - e.issue - 1;
  endfunction

  function automatic int rem_tnew(inflight_t e);
    int a;
    a = age_of(e);
    return (e.tnew0 > a) ? e.tnew0 - a : 0;
  endfunction

  function automatic void src_model(input logic [REG_W-1:0] r, input int tuse, output bit st, output int code);
    st = 0;
    code = 0;
    if (r == 0 || tuse == NOUSE) return;
    for (int a = 0; a < 3; a++)
      foreach (q[i])
        if (age_of(q[i]) == a && q[i].wreg == r) begin
          st   = rem_tnew(q[i]) > tuse;
          code = (rem_tnew(q[i]) == 0) ? a + 1 : 0;
          return;
        end
  endfunction

  function automatic int efwd_model(input logic [REG_W-1:0] r);
    if (r == 0) return 0;
    for (int a = 1; a < 3; a++)
      foreach (q[i])
        if (age_of(q[i]) == a && q[i].wreg == r && rem_tnew(q[i]) == 0) return a;
    return 0;
  endfunction

  bit               m_srs, m_srt, m_busy, m_st;
  int               m_crs, m_crt, m_ers, m_ert;
  logic [REG_W-1:0] m_e_rs, m_e_rt;

  always @(negedge clk) begin
    src_model(d_rs, int'(d_tuse_rs), m_srs, m_crs);
    src_model(d_rt, int'(d_tuse_rt), m_srt, m_crt);
    m_busy = (cyc <= md_end);
    m_st   = d_valid && (m_srs || m_srt || ((d_md_start || d_md_use) && m_busy));
    m_e_rs = '0;
    m_e_rt = '0;
    foreach (q[i])
      if (age_of(q[i]) == 0) begin
        m_e_rs = q[i].rs;
        m_e_rt = q[i].rt;
      end
    m_ers = efwd_model(m_e_rs);
    m_ert = efwd_model(m_e_rt);
    if (!reset) begin
      m_st = 0; m_busy = 0; m_crs = 0; m_crt = 0; m_ers = 0; m_ert = 0;
    end
    exp_stall_q = m_st;
    check("stall", stall, m_st);
    check("flush_e", flush_e, m_st);
    check("md_busy", md_busy, m_busy);
    check("fwd_rs_d", fwd_rs_d, m_crs);
    check("fwd_rt_d", fwd_rt_d, m_crt);
    check("fwd_rs_e", fwd_rs_e, m_ers);
    check("fwd_rt_e", fwd_rt_e, m_ert);
  end

  always @(posedge clk) begin
    if (!reset) begin
      q.delete();
      md_end = -1;
    end else if (d_valid && !exp_stall_q) begin
      q.push_front('{d_wreg, int'(d_tnew), d_rs, d_rt, cyc});
      if (d_md_start) md_end = cyc + (d_md_is_div ? 10 : 5);
    end
    cyc++;
    while (q.size() > 0 && age_of(q[$]) > 2) void'(q.pop_back());
  end

  // ---------------- stimulus ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input int wreg, input int tnew, input int rs, input int trs,
                       input int rt, input int trt, input logic st, input logic dv, input logic mu);
    d_valid     = v;
    d_wreg      = REG_W'(wreg);
    d_tnew      = TW'(tnew);
    d_rs        = REG_W'(rs);
    d_tuse_rs   = TW'(trs);
    d_rt        = REG_W'(rt);
    d_tuse_rt   = TW'(trt);
    d_md_start  = st;
    d_md_is_div = dv;
    d_md_use    = mu;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, NOUSE, 0, NOUSE, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    nop();
    repeat (n) next();
  endtask

  initial begin
    nop();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sample();
    check("rst_stall", stall, 0);
    check("rst_md_busy", md_busy, 0);
    next();
    reset = 1'b1;
    idle(1);

    // lw $8 (tnew 2) followed by addu rs=$8 (tuse 1)
    drive(1, 8, 2, 29, 1, 0, NOUSE, 0, 0, 0);
    sample(); check("lw_issue_stall", stall, 0); next();
    drive(1, 11, 1, 8, 1, 0, 1, 0, 0, 0);
    sample(); check("load_use_stall", stall, 1); check("load_use_flush", flush_e, 1); next();
    sample(); check("load_use_release", stall, 0); check("load_use_fwd_d", fwd_rs_d, 0); next();
    drive(1, 14, 1, 0, NOUSE, 8, 0, 0, 0, 0);
    sample(); check("lw_fwd_e_w", fwd_rs_e, 2); check("lw_fwd_d_w", fwd_rt_d, 3); next();
    idle(3);

    // addu $9 (tnew 1) followed by beq rs=$9 (tuse 0)
    drive(1, 9, 1, 3, NOUSE, 0, NOUSE, 0, 0, 0);
    next();
    drive(1, 0, 0, 9, 0, 0, NOUSE, 0, 0, 0);
    sample(); check("alu_br_stall", stall, 1); next();
    sample(); check("alu_br_release", stall, 0); check("alu_br_fwd_m", fwd_rs_d, 2); next();
    idle(3);

    // A write to $0 never creates a dependency
    drive(1, 0, 1, 6, 1, 0, NOUSE, 0, 0, 0);
    next();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    sample(); check("r0_stall", stall, 0); check("r0_fwd", fwd_rs_d, 0); next();
    idle(3);

    // E and M both write $10 with tnew 0: the youngest (E) wins
    drive(1, 10, 0, 0, NOUSE, 0, NOUSE, 0, 0, 0);
    next();
    next();
    drive(1, 15, 1, 10, 0, 10, 0, 0, 0, 0);
    sample(); check("youngest_rs", fwd_rs_d, 1); check("youngest_rt", fwd_rt_d, 1);
    check("youngest_stall", stall, 0); next();
    nop();
    sample(); check("youngest_e_rs", fwd_rs_e, 1); check("youngest_e_rt", fwd_rt_e, 1); next();
    idle(2);

    // A source with all-ones tuse is not read; tnew equal to tuse does not stall
    drive(1, 12, 2, 0, NOUSE, 0, NOUSE, 0, 0, 0);
    next();
    drive(1, 0, 0, 0, NOUSE, 12, NOUSE, 0, 0, 0);
    sample(); check("nouse_stall", stall, 0); check("nouse_fwd", fwd_rt_d, 0); next();
    idle(3);
    drive(1, 13, 2, 0, NOUSE, 0, NOUSE, 0, 0, 0);
    next();
    drive(1, 0, 0, 0, NOUSE, 13, 2, 0, 0, 0);
    sample(); check("tuse_eq_stall", stall, 0); check("tuse_eq_fwd", fwd_rt_d, 0); next();
    idle(3);

    // mult then mfhi: five busy/stall cycles, after which mfhi reaches E
    drive(1, 0, 0, 4, 1, 5, 1, 1, 0, 0);
    sample(); check("mult_issue_stall", stall, 0); check("mult_issue_busy", md_busy, 0); next();
    drive(1, 2, 1, 0, NOUSE, 0, NOUSE, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      sample(); check("mult_busy", md_busy, 1); check("mult_stall", stall, 1); next();
    end
    sample(); check("mult_done_busy", md_busy, 0); check("mult_done_stall", stall, 0); next();
    drive(1, 0, 0, 2, 0, 0, NOUSE, 0, 0, 0);
    sample(); check("mfhi_in_e", stall, 1); next();
    sample(); check("mfhi_fwd_m", fwd_rs_d, 2); next();
    idle(3);

    // div: ten busy cycles; an invalid D slot never stalls
    drive(1, 0, 0, 4, 1, 5, 1, 1, 1, 0);
    next();
    drive(0, 0, 0, 0, NOUSE, 0, NOUSE, 0, 0, 1);
    sample(); check("div_invalid_stall", stall, 0); check("div_busy_first", md_busy, 1); next();
    drive(1, 2, 1, 0, NOUSE, 0, NOUSE, 0, 0, 1);
    for (int i = 0; i < 9; i++) begin
      sample(); check("div_stall", stall, 1); next();
    end
    sample(); check("div_done_busy", md_busy, 0); check("div_done_stall", stall, 0); next();
    idle(3);

    // Reset asserted for one edge while a load-use stall is pending and mult is busy
    drive(1, 0, 0, 4, 1, 5, 1, 1, 0, 0);
    next();
    drive(1, 8, 2, 0, NOUSE, 0, NOUSE, 0, 0, 0);
    next();
    drive(1, 11, 1, 8, 1, 0, NOUSE, 0, 0, 0);
    sample(); check("pre_rst_stall", stall, 1); check("pre_rst_busy", md_busy, 1);
    #2 reset = 1'b0;
    #1 check("rst_low_stall", stall, 0); check("rst_low_busy", md_busy, 0);
    next();
    reset = 1'b1;
    sample(); check("post_rst_stall", stall, 0); check("post_rst_busy", md_busy, 0);
    check("post_rst_fwd", fwd_rs_d, 0); next();
    idle(3);
    sample();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
